// File: rtl/tow_arena.sv
// tow_arena: parametrised tug-of-war match engine.
// Two raw buttons in, LED playfield out. Runs hold-off, live window,
// first-press detection, false start / tie handling and marker movement
// until the marker reaches either end LED.
module tow_arena #(
    parameter int NUM_LEDS   = 7,
    parameter int PRESCALE   = 256,
    parameter int MIN_WAIT   = 32,
    parameter int SHOW_TICKS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_l,
    input  logic                btn_r,
    output logic [NUM_LEDS-1:0] leds_out,
    output logic                round_live,
    output logic                match_over,
    output logic                winner_l,
    output logic [7:0]          round_cnt
);

    localparam int PW = $clog2(NUM_LEDS);
    localparam int CW = $clog2(PRESCALE);
    localparam int WW = $clog2(MIN_WAIT + 32);
    localparam int SW = $clog2(SHOW_TICKS + 1);

    localparam logic [PW-1:0] POS_MID = PW'((NUM_LEDS - 1) / 2);
    localparam logic [PW-1:0] POS_MAX = PW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        CLEAR,
        WAIT,
        LIVE,
        SHOW,
        WON
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [PW-1:0]         pos;
    logic [PW-1:0]         pos_nx;
    logic [2:0]            sync_l;
    logic [2:0]            sync_r;
    logic                  press_l;
    logic                  press_r;
    logic [CW-1:0]         presc;
    logic                  tick;
    logic [7:0]            lfsr;
    logic [WW-1:0]         wait_cnt;
    logic [SW-1:0]         show_cnt;
    logic [3:0]            blink_cnt;
    logic                  blink_on;
    logic                  load_wait;
    logic                  round_done;
    logic                  left_win;
    logic                  right_win;
    logic [NUM_LEDS-1:0]   one_hot;

    // Button synchronisers: bits [1:0] are the 2-flop synchroniser, bit 2 holds the previous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_l <= '0;
            sync_r <= '0;
        end else begin
            sync_l <= {sync_l[1:0], btn_l};
            sync_r <= {sync_r[1:0], btn_r};
        end
    end

    assign press_l = sync_l[1] & ~sync_l[2];
    assign press_r = sync_r[1] & ~sync_r[2];

    // Free-running prescaler; tick is high for the last cycle of each period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == CW'(PRESCALE - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == CW'(PRESCALE - 1));

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepping every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Round controller next-state, round result and marker update.
    always_comb begin
        state_nx   = state;
        pos_nx     = pos;
        load_wait  = 1'b0;
        round_done = 1'b0;
        left_win   = 1'b0;
        right_win  = 1'b0;
        case (state)
            CLEAR: begin
                if (!sync_l[1] && !sync_r[1]) begin
                    state_nx  = WAIT;
                    load_wait = 1'b1;
                end
            end
            WAIT: begin
                if (press_l && press_r) begin
                    round_done = 1'b1;
                end else if (press_l) begin
                    round_done = 1'b1;
                    right_win  = 1'b1;
                end else if (press_r) begin
                    round_done = 1'b1;
                    left_win   = 1'b1;
                end else if (wait_cnt == '0) begin
                    state_nx = LIVE;
                end
            end
            LIVE: begin
                if (press_l && press_r) begin
                    round_done = 1'b1;
                end else if (press_l) begin
                    round_done = 1'b1;
                    left_win   = 1'b1;
                end else if (press_r) begin
                    round_done = 1'b1;
                    right_win  = 1'b1;
                end
            end
            SHOW: begin
                if (show_cnt == '0) begin
                    state_nx = (pos == '0 || pos == POS_MAX) ? WON : CLEAR;
                end
            end
            WON: begin
                state_nx = WON;
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase
        if (round_done) begin
            state_nx = SHOW;
        end
        if (left_win && pos != POS_MAX) begin
            pos_nx = pos + 1'b1;
        end
        if (right_win && pos != '0) begin
            pos_nx = pos - 1'b1;
        end
    end

    // State and marker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            pos   <= POS_MID;
        end else begin
            state <= state_nx;
            pos   <= pos_nx;
        end
    end

    // Hold-off, result display and completed-round counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            show_cnt  <= '0;
            round_cnt <= '0;
        end else begin
            if (load_wait) begin
                wait_cnt <= WW'(MIN_WAIT) + WW'(lfsr[4:0]);
            end else if (state == WAIT && tick && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (round_done) begin
                show_cnt <= SW'(SHOW_TICKS);
            end else if (state == SHOW && tick && show_cnt != '0) begin
                show_cnt <= show_cnt - 1'b1;
            end
            if (round_done && round_cnt != 8'hFF) begin
                round_cnt <= round_cnt + 8'd1;
            end
        end
    end

    // End-LED blinker: parked lit outside WON so it starts lit on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state != WON) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tick) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (blink_cnt == 4'hF) begin
                blink_on <= ~blink_on;
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        one_hot = NUM_LEDS'(1) << pos;
        case (state)
            LIVE:    leds_out = '1;
            WON:     leds_out = blink_on ? one_hot : '0;
            default: leds_out = one_hot;
        endcase
        round_live = (state == LIVE);
        match_over = (state == WON);
        winner_l   = (state == WON) && (pos == POS_MAX);
    end

endmodule

// File: tb/tb_tow_arena.sv
// tb_tow_arena: self-checking bench for tow_arena.
// Two instances (7 and 5 LEDs) share clock, reset and buttons; a behavioural
// game model per instance predicts every output every cycle.
module tb_tow_arena;

    localparam int P  = 4;
    localparam int MW = 2;
    localparam int ST = 2;

    localparam int PH_CLEAR = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_LIVE  = 2;
    localparam int PH_SHOW  = 3;
    localparam int PH_WON   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic [6:0] leds7;
    logic [4:0] leds5;
    logic       live7, over7, win7;
    logic       live5, over5, win5;
    logic [7:0] rc7, rc5;

    int total = 0;
    int bad   = 0;

    // model state
    int n_edge;
    int lf;
    bit hl [3];
    bit hr [3];
    int ph [2];
    int pos [2];
    int rc [2];
    int wc [2];
    int sc [2];
    int bc [2];
    bit lit [2];
    int nl [2] = '{7, 5};

    always #5 clk = ~clk;

    tow_arena #(.NUM_LEDS(7), .PRESCALE(P), .MIN_WAIT(MW), .SHOW_TICKS(ST)) u7 (
        .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r),
        .leds_out(leds7), .round_live(live7), .match_over(over7),
        .winner_l(win7), .round_cnt(rc7)
    );

    tow_arena #(.NUM_LEDS(5), .PRESCALE(P), .MIN_WAIT(MW), .SHOW_TICKS(ST)) u5 (
        .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r),
        .leds_out(leds5), .round_live(live5), .match_over(over5),
        .winner_l(win5), .round_cnt(rc5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d]  = PH_CLEAR;
            pos[d] = (nl[d] - 1) / 2;
            rc[d]  = 0;
            wc[d]  = 0;
            sc[d]  = 0;
            bc[d]  = 0;
            lit[d] = 1'b1;
        end
        n_edge = 0;
        lf     = 1;
        for (int i = 0; i < 3; i++) begin
            hl[i] = 1'b0;
            hr[i] = 1'b0;
        end
    endtask

    // One game rule step for instance d. Round outcome: 1 left, 2 right, 3 tie.
    task automatic m_dut(input int d, input bit pl, input bit pr, input bit tk);
        int outcome;
        outcome = 0;
        case (ph[d])
            PH_CLEAR: if (!hl[1] && !hr[1]) begin
                ph[d] = PH_WAIT;
                wc[d] = MW + (lf % 32);
            end
            PH_WAIT: begin
                if (pl && pr) outcome = 3;
                else if (pl) outcome = 2;
                else if (pr) outcome = 1;
                else if (wc[d] == 0) ph[d] = PH_LIVE;
                else if (tk) wc[d] = wc[d] - 1;
            end
            PH_LIVE: begin
                if (pl && pr) outcome = 3;
                else if (pl) outcome = 1;
                else if (pr) outcome = 2;
            end
            PH_SHOW: begin
                if (sc[d] == 0) begin
                    if (pos[d] == 0 || pos[d] == nl[d] - 1) begin
                        ph[d]  = PH_WON;
                        bc[d]  = 0;
                        lit[d] = 1'b1;
                    end else begin
                        ph[d] = PH_CLEAR;
                    end
                end else if (tk) begin
                    sc[d] = sc[d] - 1;
                end
            end
            default: if (tk) begin
                bc[d] = bc[d] + 1;
                if (bc[d] == 16) begin
                    bc[d]  = 0;
                    lit[d] = !lit[d];
                end
            end
        endcase
        if (outcome != 0) begin
            if (outcome == 1 && pos[d] < nl[d] - 1) pos[d] = pos[d] + 1;
            if (outcome == 2 && pos[d] > 0) pos[d] = pos[d] - 1;
            rc[d] = (rc[d] < 255) ? rc[d] + 1 : 255;
            sc[d] = ST;
            ph[d] = PH_SHOW;
        end
    endtask

    task automatic m_edge();
        bit pl, pr, tk;
        pl = hl[1] && !hl[2];
        pr = hr[1] && !hr[2];
        tk = (n_edge % P) == P - 1;
        for (int d = 0; d < 2; d++) m_dut(d, pl, pr, tk);
        lf = ((lf << 1) | ($countones(lf & 'hB8) % 2)) & 'hFF;
        hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = btn_l;
        hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = btn_r;
        n_edge++;
    endtask

    function automatic logic [31:0] m_exp(input int d);
        int leds, lv, ov, wl;
        if (ph[d] == PH_LIVE) leds = (1 << nl[d]) - 1;
        else if (ph[d] == PH_WON) leds = lit[d] ? (1 << pos[d]) : 0;
        else leds = 1 << pos[d];
        lv = (ph[d] == PH_LIVE) ? 1 : 0;
        ov = (ph[d] == PH_WON) ? 1 : 0;
        wl = (ph[d] == PH_WON && pos[d] == nl[d] - 1) ? 1 : 0;
        return 32'((leds << 11) | (lv << 10) | (ov << 9) | (wl << 8) | rc[d]);
    endfunction

    task automatic cmp_all();
        chk("cyc7", {14'b0, leds7, live7, over7, win7, rc7}, m_exp(0));
        chk("cyc5", {16'b0, leds5, live5, over5, win5, rc5}, m_exp(1));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) m_edge();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        #1;
        cmp_all();
        chk("rst_leds7", 32'(leds7), 32'(7'b0001000));
        chk("rst_leds5", 32'(leds5), 32'(5'b00100));
        chk("rst_rc7", 32'(rc7), 32'd0);
        chk("rst_over7", 32'(over7), 32'd0);
        chk("rst_live7", 32'(live7), 32'd0);
        chk("rst_win7", 32'(win7), 32'd0);
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic wait_live(input string tag);
        int k;
        k = 0;
        while (!live7 && k < 400) begin
            step();
            k++;
        end
        chk(tag, 32'(live7), 32'd1);
    endtask

    task automatic press_live(input bit l, input bit r, input string tag);
        btn_l = l;
        btn_r = r;
        step();
        step();
        chk({tag, "_live_hold"}, 32'(live7), 32'd1);
        step();
        chk({tag, "_live_fall"}, 32'(live7), 32'd0);
    endtask

    initial begin
        int k, t, lv, pat;
        m_reset();
        @(negedge clk);

        // false start by right, then right held across SHOW
        do_reset();
        step();
        step();
        btn_r = 1'b1;
        repeat (3) step();
        chk("fs_leds7", 32'(leds7), 32'(7'b0010000));
        chk("fs_leds5", 32'(leds5), 32'(5'b01000));
        chk("fs_rc7", 32'(rc7), 32'd1);
        lv = 0;
        repeat (200) begin
            step();
            lv += int'(live7);
        end
        chk("held_block", 32'(lv), 32'd0);
        btn_r = 1'b0;

        // tie in LIVE
        wait_live("live_tie");
        press_live(1'b1, 1'b1, "tie");
        chk("tie_leds7", 32'(leds7), 32'(7'b0010000));
        chk("tie_rc7", 32'(rc7), 32'd2);
        btn_l = 1'b0;
        btn_r = 1'b0;

        // normal left win
        wait_live("live_lw");
        press_live(1'b1, 1'b0, "lw");
        chk("lw_leds7", 32'(leds7), 32'(7'b0100000));
        chk("lw_rc7", 32'(rc7), 32'd3);
        btn_l = 1'b0;

        // five-LED match: two left live wins
        do_reset();
        wait_live("live_m1");
        press_live(1'b1, 1'b0, "m1");
        btn_l = 1'b0;
        chk("m1_leds5", 32'(leds5), 32'(5'b01000));
        wait_live("live_m2");
        press_live(1'b1, 1'b0, "m2");
        btn_l = 1'b0;
        k = 0;
        while (!over5 && k < 100) begin
            step();
            k++;
        end
        chk("won_over5", 32'(over5), 32'd1);
        chk("won_win5", 32'(win5), 32'd1);
        chk("won_leds5", 32'(leds5), 32'(5'b10000));
        t = 0;
        while (leds5 == 5'b10000 && t < 200) begin
            step();
            t++;
        end
        chk("blink_first", 32'(t >= 61 && t <= 64), 32'd1);
        chk("blink_dark", 32'(leds5), 32'd0);
        t = 0;
        while (leds5 == 5'b00000 && t < 200) begin
            step();
            t++;
        end
        chk("blink_off_len", 32'(t), 32'd64);
        repeat (4) begin
            btn_l = 1'b1;
            btn_r = 1'($urandom_range(0, 1));
            repeat (3) step();
            btn_l = 1'b0;
            btn_r = 1'b0;
            repeat (10) step();
        end
        chk("won_rc5", 32'(rc5), 32'd2);
        chk("won_hold5", 32'(over5), 32'd1);

        // reset mid-WAIT and mid-SHOW
        do_reset();
        repeat (5) step();
        do_reset();
        wait_live("live_ms");
        btn_l = 1'b1;
        repeat (3) step();
        btn_l = 1'b0;
        do_reset();

        // LFSR restarts from seed: seed 01 gives 3-tick hold-off, LIVE after edge 13
        for (int run = 0; run < 2; run++) begin
            t = 0;
            while (!live7 && t < 400) begin
                step();
                t++;
            end
            chk("lfsr_repeat", 32'(t), 32'd13);
            do_reset();
        end

        // randomized play
        repeat (60) begin
            if (over7 || $urandom_range(0, 9) == 0) do_reset();
            if ($urandom_range(0, 1) == 1) wait_live("live_rand");
            repeat ($urandom_range(0, 150)) step();
            pat   = int'($urandom_range(1, 3));
            btn_l = pat[0];
            btn_r = pat[1];
            repeat ($urandom_range(1, 30)) step();
            btn_l = 1'b0;
            btn_r = 1'b0;
            repeat ($urandom_range(0, 20)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tow_arena.md
# tow_arena

Parametrised tug-of-war match engine: the N-LED successor to the fixed 7-LED game top. It takes two raw player buttons and runs the full round sequence on its own: random hold-off, "go" display, first-press detection, false-start and tie handling, and rope-marker movement. A match is won when the marker reaches either end LED. It integrates the prescaler, LFSR, synchroniser and round controller internally and sits directly between the board buttons and the LED bank.

## Interface

Parameters:
- NUM_LEDS, 7: playfield width. Must be odd, minimum 3. Marker starts at the centre LED.
- PRESCALE, 256: clk cycles per game tick. Minimum 2.
- MIN_WAIT, 32: minimum random hold-off, in ticks. Minimum 1.
- SHOW_TICKS, 64: ticks the round result is displayed. Minimum 1.

Ports:
- clk  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- btn_l  in  1  left player button, raw and asynchronous, active-high.
- btn_r  in  1  right player button, raw and asynchronous, active-high.
- leds_out  out  NUM_LEDS  playfield LEDs; bit NUM_LEDS-1 is the leftmost LED.
- round_live  out  1  high while in LIVE.
- match_over  out  1  high while in WON.
- winner_l  out  1  in WON: 1 means left won, 0 means right won. Reads 0 outside WON.
- round_cnt  out  8  number of completed rounds, saturating at 255.

## Operation

Input path:
- Each button passes through a 2-flop synchroniser (s1, s2), then a third flop s3.
- press_x = s2 & ~s3, i.e. a press is a rising edge of the synchronised level.
- A held button never generates a second press.

Tick and random source:
- tick is a 1-cycle pulse every PRESCALE clk cycles, from a free-running counter cleared by reset.
- The LFSR is 8 bits, polynomial x^8+x^6+x^5+x^4+1, seeded 8'h01 on reset, and advances every clk cycle.

Marker:
- pos is clog2(NUM_LEDS) bits wide; reset value is (NUM_LEDS-1)/2.
- A left round win does pos+1; a right round win does pos-1.
- pos never leaves the range [0, NUM_LEDS-1].

State machine (reset state CLEAR):
- CLEAR: leds_out = one-hot(pos). When both synchronised levels s2 are 0, go to WAIT and load wait_cnt = MIN_WAIT + lfsr[4:0].
- WAIT: leds_out = one-hot(pos). wait_cnt decrements on tick; at 0, go to LIVE.
  - A single press in WAIT is a false start: the opponent wins the round, go to SHOW.
  - Both presses in the same cycle: tie, go to SHOW.
- LIVE: leds_out = all ones.
  - The first press_x wins the round for player x, go to SHOW.
  - press_l and press_r in the same cycle: tie, pos unchanged, go to SHOW.
- SHOW: leds_out = one-hot(pos), already updated.
  - On entry, round_cnt increments (saturating) and show_cnt = SHOW_TICKS; show_cnt decrements on tick.
  - At 0: if pos is 0 or NUM_LEDS-1, go to WON; otherwise go to CLEAR.
- WON: winner_l = (pos == NUM_LEDS-1). The end LED blinks, toggling every 16 ticks, starting lit. The block holds in WON until rst; buttons are ignored.

Reset values of outputs: leds_out = one-hot centre, round_live = 0, match_over = 0, winner_l = 0, round_cnt = 0.

## Timing

- Button to action: a button asserted before edge k is seen as a press during cycle k+1, and the state/pos update lands at edge k+2. That is 3 rising edges of latency including the sampling edge.
- State, pos and round_cnt update on the same edge. Outputs are decoded from registered state with no added latency.
- WAIT lasts (MIN_WAIT + lfsr[4:0]) ticks, i.e. MIN_WAIT to MIN_WAIT+31 ticks, to within one tick of phase.
- SHOW lasts SHOW_TICKS ticks, to within one tick of phase.
- Presses in CLEAR, SHOW and WON are discarded.
- A button still held from a previous round blocks CLEAR→WAIT until it is released.
- rst asserted in any state forces the reset values asynchronously. The first legal transition happens on the first rising edge after rst deasserts.

## Test plan

Use PRESCALE=4, MIN_WAIT=2, SHOW_TICKS=2 unless stated.

- Reset: assert rst with NUM_LEDS=7 -> leds_out=7'b0001000, round_cnt=0, match_over=0, and the state reaches WAIT one edge after rst deasserts.
- Normal left win: press btn_l in LIVE -> round_live falls 3 edges after the press, leds_out=7'b0010000, round_cnt=1; after SHOW the block returns to CLEAR and then WAIT.
- False start: pulse btn_r during WAIT -> left wins the round and leds_out=7'b0010000. A btn_r held across SHOW keeps the block in CLEAR until released.
- Tie: assert btn_l and btn_r on the same edge in LIVE -> pos unchanged (7'b0001000) and round_cnt increments.
- Match win: NUM_LEDS=5, two left LIVE wins -> WON, match_over=1, winner_l=1, leds_out toggles between 5'b10000 and 0 every 16 ticks, and further presses have no effect.
- Reset mid-operation: assert rst mid-WAIT and mid-SHOW -> immediate reset values; with stimulus reapplied, the LFSR sequence repeats exactly from the seed.
